// File: rtl/token_pkg.sv
// Shared constants and elaboration-time parameter checking for the token coalescer.
package token_pkg;

    localparam int CNT_W_DEFAULT   = 4;
    localparam int BATCH_DEFAULT   = 8;
    localparam int TIMEOUT_DEFAULT = 16;

    function automatic bit params_ok(input int cnt_w, input int batch, input int timeout);
        return (cnt_w >= 1) && (cnt_w <= 30) && (batch >= 1) &&
               (batch <= ((1 << cnt_w) - 1)) && (timeout >= 1);
    endfunction

endpackage

// File: rtl/token_idle_timer.sv
// Saturating idle counter: counts enabled cycles, restarts on clear, flags TIMEOUT-1 reached.
module token_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] LAST = IW'(TIMEOUT - 1);

    logic [IW-1:0] r_idle;

    assign o_expired = (r_idle == LAST);

    // Saturation keeps a blocked flush pending until a slot frees up.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_idle <= '0;
        end else if (i_count && !o_expired) begin
            r_idle <= r_idle + IW'(1);
        end
    end

endmodule

// File: rtl/token_coalescer.sv
// Drains tokens from a data-less FIFO and emits batch counts; partial-batch timeout
// flush is built only when TOKEN_COALESCER_TIMEOUT_EN is defined.
module token_coalescer
    import token_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int BATCH   = BATCH_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_EMPTY_N,
    output logic             IN_DEQ,
    output logic             OUT_VALID,
    output logic [CNT_W-1:0] OUT_COUNT,
    input  logic             OUT_READY,
    input  logic             CLR
);

    if (!params_ok(CNT_W, BATCH, TIMEOUT)) begin : g_param_err
        $fatal(1, "token_coalescer: illegal CNT_W/BATCH/TIMEOUT");
    end

    localparam logic [CNT_W-1:0] BATCH_C = CNT_W'(BATCH);

    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_out;
    logic             r_vld;

    logic [CNT_W-1:0] w_inc;
    logic             w_deq;
    logic             w_fire;
    logic             w_slot;
    logic             w_flush;
    logic             w_load;

    assign w_deq  = IN_EMPTY_N && !CLR && (r_acc != BATCH_C);
    assign w_inc  = r_acc + CNT_W'(w_deq);
    assign w_fire = r_vld && OUT_READY;
    assign w_slot = !r_vld || w_fire;
    assign w_load = w_slot && ((w_inc == BATCH_C) || w_flush);

`ifdef TOKEN_COALESCER_TIMEOUT_EN
    logic w_expired;

    token_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk       (CLK),
        .i_clear   (RST || CLR || w_deq || w_load),
        .i_count   ((r_acc != '0) && !w_deq),
        .o_expired (w_expired)
    );

    assign w_flush = (r_acc != '0) && w_expired;
`else
    assign w_flush = 1'b0;
`endif

    // A handshake coinciding with CLR is dropped along with everything held.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            r_acc <= '0;
            r_out <= '0;
            r_vld <= 1'b0;
        end else if (w_load) begin
            r_out <= w_inc;
            r_vld <= 1'b1;
            r_acc <= '0;
        end else begin
            r_acc <= w_inc;
            if (w_fire) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign IN_DEQ    = w_deq;
    assign OUT_VALID = r_vld;
    assign OUT_COUNT = r_out;

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (r_vld && (r_out == '0)) begin
                $warning("token_coalescer: OUT_COUNT is 0 while OUT_VALID is high");
            end
            if (r_acc > BATCH_C) begin
                $warning("token_coalescer: accumulator above BATCH");
            end
        end
    end
`endif

endmodule
